// File: rtl/ko4_mul_merge_pkg.sv
// ---------------------------------------------------------------------------
// ko4_mul_merge_pkg
// Shared sizing and types for the KO4 multiplier recombination (merge) stage.
//   DATA_WIDTH    operand width
//   KO_PARAMETER  slice count
//   SLICE_W       slice width            (DATA_WIDTH / KO_PARAMETER)
//   COEF_W        coefficient width      (2*SLICE_W + 2, four summed products)
//   NCOEF         coefficients / product (2*KO_PARAMETER - 1)
//   PROD_W        final product width    (2*DATA_WIDTH)
//   IDX_W         coefficient index / beat counter width
// ---------------------------------------------------------------------------
package ko4_mul_merge_pkg;

  localparam int DATA_WIDTH   = 72;
  localparam int KO_PARAMETER = 4;
  localparam int SLICE_W      = DATA_WIDTH / KO_PARAMETER;
  localparam int COEF_W       = 2 * SLICE_W + 2;
  localparam int NCOEF        = 2 * KO_PARAMETER - 1;
  localparam int PROD_W       = 2 * DATA_WIDTH;
  localparam int IDX_W        = 3;

  // Merge control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } merge_state_e;

  // Zero-extend a coefficient to the product width before shifting, so no
  // high coefficient bits are lost before they reach the product boundary.
  function automatic logic [PROD_W-1:0] zext_coef(input logic [COEF_W-1:0] c);
    return {{(PROD_W - COEF_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/ko4_mul_merge_if.sv
// ---------------------------------------------------------------------------
// ko4_mul_merge_if
// Coefficient-in / product-out stream bundle for ko4_mul_merge.
//   flush      synchronous abort of the in-progress product
//   in_valid   coefficient beat valid
//   in_ready   merge can accept a beat
//   in_coef    coefficient c_k (beat k carries c_k)
//   in_idx     coefficient index tag
//   out_valid  product valid
//   out_ready  downstream accepts the product
//   out_prod   final product
//   err        sticky index-mismatch flag
// Modports: slave = the merge stage, master = the surrounding logic.
// ---------------------------------------------------------------------------
interface ko4_mul_merge_if;
  import ko4_mul_merge_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_coef;
  logic [IDX_W-1:0]  in_idx;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_prod;
  logic              err;

  modport slave (
    input  flush, in_valid, in_coef, in_idx, out_ready,
    output in_ready, out_valid, out_prod, err
  );

  modport master (
    output flush, in_valid, in_coef, in_idx, out_ready,
    input  in_ready, out_valid, out_prod, err
  );

endinterface

// File: rtl/ko4_merge_shift_add.sv
// ---------------------------------------------------------------------------
// ko4_merge_shift_add
// Combinational shift-and-add: sum = acc + (coef << cnt*SLICE_W), modulo
// 2^PROD_W. Kept in its own module so the barrel-shift/add path is a single
// timing-isolated block.
//   acc   running partial product
//   coef  incoming coefficient
//   cnt   coefficient index (selects the slice-aligned shift)
//   sum   updated partial product
// ---------------------------------------------------------------------------
module ko4_merge_shift_add
  import ko4_mul_merge_pkg::*;
(
  input  logic [PROD_W-1:0] acc,
  input  logic [COEF_W-1:0] coef,
  input  logic [IDX_W-1:0]  cnt,
  output logic [PROD_W-1:0] sum
);

  logic [PROD_W-1:0] coef_ext;
  logic [PROD_W-1:0] shifted;

  assign coef_ext = zext_coef(coef);

  // Shifts are multiples of SLICE_W only, so a mux of constant shifts is
  // enough; bits shifted past PROD_W fall off, giving modular arithmetic.
  always_comb begin
    // NOTE: assign a default before the selection so every path drives
    // shifted; otherwise synthesis infers a latch for unmatched cnt values.
    shifted = '0;
    for (int k = 0; k < NCOEF; k++) begin
      if (cnt == IDX_W'(k)) begin
        shifted = coef_ext << (k * SLICE_W);
      end
    end
  end

  assign sum = acc + shifted;

endmodule

// File: rtl/ko4_mul_merge.sv
// ---------------------------------------------------------------------------
// ko4_mul_merge
// Recombination stage of the KO4 multiplier. Accepts the NCOEF slice
// convolution coefficients c0..c6 (lowest index first) as a valid/ready
// stream, accumulates P = sum(c_i << i*SLICE_W) in a single accumulator and
// presents P on a held valid/ready output.
//   clk   clock, rising edge
//   rst   asynchronous reset, active-high
//   bus   ko4_mul_merge_if.slave (flush, coefficient input, product output)
// Configuration:
//   KO_MERGE_IDX_CHK_EN  when defined, each accepted beat's in_idx is
//                        compared with the expected index; a mismatching
//                        beat is consumed without effect and sets the sticky
//                        err flag. When undefined, in_idx is ignored and
//                        err is tied low.
// ---------------------------------------------------------------------------
module ko4_mul_merge
  import ko4_mul_merge_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  ko4_mul_merge_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOEF - 1);

  merge_state_e      state;
  logic [IDX_W-1:0]  cnt;
  logic [PROD_W-1:0] acc;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              accept;
  logic              idx_ok;
  logic [PROD_W-1:0] acc_base;
  logic [PROD_W-1:0] acc_next;

  // A beat transfers only when the registered ready is high; ready never
  // looks at out_ready, so there is no output-to-input bypass.
  assign accept = bus.in_valid & in_ready_q;

  // The first beat of a product starts from zero, not from the previous
  // product still sitting in acc.
  assign acc_base = (state == ST_IDLE) ? '0 : acc;

`ifdef KO_MERGE_IDX_CHK_EN
  assign idx_ok = (bus.in_idx == cnt);
`else
  assign idx_ok = 1'b1;
  logic unused_idx;
  assign unused_idx = ^bus.in_idx;
`endif

  ko4_merge_shift_add u_shift_add (
    .acc  (acc_base),
    .coef (bus.in_coef),
    .cnt  (cnt),
    .sum  (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over any same-cycle handshake; that beat/product is lost.
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept && idx_ok) begin
            acc   <= acc_next;
            cnt   <= IDX_W'(1);
            state <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          // in_valid gaps simply hold state, cnt and acc.
          if (accept && idx_ok) begin
            acc <= acc_next;
            if (cnt == LAST_IDX) begin
              cnt         <= '0;
              state       <= ST_OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end

        ST_OUT: begin
          // acc is frozen here, so out_prod stays stable under backpressure.
          if (out_valid_q && bus.out_ready) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef KO_MERGE_IDX_CHK_EN
  logic err_q;

  // Sticky until reset or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.flush) begin
      err_q <= 1'b0;
    end else if (accept && !idx_ok) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = acc;

endmodule

// File: tb/tb_ko4_mul_merge.sv
// ---------------------------------------------------------------------------
// tb_ko4_mul_merge
// Self-checking bench for ko4_mul_merge. Coefficients are produced by
// splitting operands into slices and convolving them; the expected product
// is the plain a*b. A compare process checks every valid output cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ko4_mul_merge;
  import ko4_mul_merge_pkg::*;

  typedef logic [COEF_W-1:0]     coef_t;
  typedef logic [PROD_W-1:0]     prod_t;
  typedef logic [DATA_WIDTH-1:0] op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ko4_mul_merge_if bus ();

  ko4_mul_merge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  prod_t exp_q[$];
  coef_t cbuf [NCOEF];
  int    gap_max   = 0;
  logic  hold_ready = 1'b1;
  logic  rnd_ready  = 1'b0;
  logic  rnd_bit    = 1'b0;

  assign bus.out_ready = rnd_ready ? rnd_bit : hold_ready;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input prod_t act, input prod_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Model: operand split + slice convolution, and the reference product.
  task automatic split_conv(input op_t a, input op_t b);
    for (int i = 0; i < NCOEF; i++) cbuf[i] = '0;
    for (int j = 0; j < KO_PARAMETER; j++) begin
      for (int k = 0; k < KO_PARAMETER; k++) begin
        cbuf[j+k] = cbuf[j+k] + COEF_W'(a[j*SLICE_W +: SLICE_W]) * COEF_W'(b[k*SLICE_W +: SLICE_W]);
      end
    end
  endtask

  function automatic prod_t model_prod(input op_t a, input op_t b);
    return prod_t'(a) * prod_t'(b);
  endfunction

  // Compare process: every cycle the output is valid, it must match the
  // oldest outstanding product; ready is low exactly while a product is held.
  always @(negedge clk) begin
    if (!rst) begin
      check_bit("ready_vs_valid", bus.in_ready, ~bus.out_valid);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_product: got %0h want none", bus.out_prod);
        end else begin
          check("out_prod", bus.out_prod, exp_q[0]);
          if (bus.out_ready && !bus.flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  // All drivers act 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input coef_t c, input logic [IDX_W-1:0] idx);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_coef  = c;
    bus.in_idx   = idx;
    while (!bus.in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL beat_wait: in_ready low for %0d cycles, want high", waited);
    end
    tick();
    bus.in_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) tick();
  endtask

  task automatic send_prod(input prod_t expv);
    exp_q.push_back(expv);
    for (int i = 0; i < NCOEF; i++) send_beat(cbuf[i], IDX_W'(i));
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d products outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    op_t   a;
    op_t   b;
    prod_t lit;
    coef_t s;
    int    n_tab [NCOEF] = '{1, 2, 3, 4, 3, 2, 1};

    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_coef  = '0;
    bus.in_idx   = '0;

    // Reset values.
    repeat (3) tick();
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_prod", bus.out_prod, '0);
    check_bit("rst_err", bus.err, 1'b0);
    rst = 1'b0;
    tick();

    // 1*1: latency is exactly one cycle after the 7th beat.
    split_conv(op_t'(1), op_t'(1));
    check("t1_c0", prod_t'(cbuf[0]), prod_t'(1));
    send_prod(prod_t'(1));
    check_bit("t1_latency_valid", bus.out_valid, 1'b1);
    check_bit("t1_latency_ready", bus.in_ready, 1'b0);
    drain(20);
    check_bit("t1_release_valid", bus.out_valid, 1'b0);
    check_bit("t1_release_ready", bus.in_ready, 1'b1);

    // 2^18 * 2^18: only c2 is non-zero.
    a = op_t'(1) << 18;
    split_conv(a, a);
    check("t2_c2", prod_t'(cbuf[2]), prod_t'(1));
    check("t2_c0", prod_t'(cbuf[0]), prod_t'(0));
    lit = prod_t'(1) << 36;
    send_prod(lit);
    drain(20);

    // Max operands with the output held for 5 cycles.
    a = '1;
    split_conv(a, a);
    s = COEF_W'(18'h3FFFF);
    for (int i = 0; i < NCOEF; i++) check("t3_coef", prod_t'(cbuf[i]), prod_t'(COEF_W'(n_tab[i]) * s * s));
    lit = {{71{1'b1}}, {72{1'b0}}, 1'b1};
    check("t3_model", model_prod(a, a), lit);
    hold_ready = 1'b0;
    send_prod(lit);
    // Offer the next product's first beat while the output is held.
    split_conv(op_t'(1), op_t'(1));
    exp_q.push_back(prod_t'(1));
    bus.in_valid = 1'b1;
    bus.in_coef  = cbuf[0];
    bus.in_idx   = '0;
    repeat (5) begin
      tick();
      check_bit("t4_hold_valid", bus.out_valid, 1'b1);
      check_bit("t4_hold_ready", bus.in_ready, 1'b0);
      check("t4_hold_prod", bus.out_prod, lit);
    end
    hold_ready = 1'b1;
    for (int i = 0; i < NCOEF; i++) send_beat(cbuf[i], IDX_W'(i));
    drain(20);

    // flush after 3 beats, with a would-be beat in the flush cycle.
    split_conv(op_t'(12345), op_t'(67890));
    for (int i = 0; i < 3; i++) send_beat(cbuf[i], IDX_W'(i));
    bus.in_valid = 1'b1;
    bus.in_coef  = COEF_W'(9);
    bus.in_idx   = '0;
    bus.flush    = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_bit("t5_flush_valid", bus.out_valid, 1'b0);
    check_bit("t5_flush_ready", bus.in_ready, 1'b1);
    split_conv(op_t'(1), op_t'(1));
    send_prod(prod_t'(1));
    drain(20);

    // Asynchronous reset mid-ACCUM.
    split_conv(op_t'(777), op_t'(999));
    send_beat(cbuf[0], 3'd0);
    send_beat(cbuf[1], 3'd1);
    #2;
    rst = 1'b1;
    #1;
    check_bit("t5_rst_in_ready", bus.in_ready, 1'b1);
    check_bit("t5_rst_out_valid", bus.out_valid, 1'b0);
    check("t5_rst_out_prod", bus.out_prod, '0);
    check_bit("t5_rst_err", bus.err, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    split_conv(op_t'(1), op_t'(1));
    send_prod(prod_t'(1));
    drain(20);

    // Random operands with input gaps and random output backpressure.
    gap_max   = 2;
    rnd_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      a = op_t'({$urandom(), $urandom(), $urandom()});
      b = op_t'({$urandom(), $urandom(), $urandom()});
      if (t % 50 == 0) begin
        a = '1;
        b = '1;
      end
      split_conv(a, b);
      send_prod(model_prod(a, b));
    end
    drain(200);
    rnd_ready = 1'b0;
    gap_max   = 0;
    tick();

`ifdef KO_MERGE_IDX_CHK_EN
    // Wrong index on the second beat is dropped and flagged.
    a = op_t'({$urandom(), $urandom(), $urandom()});
    b = op_t'({$urandom(), $urandom(), $urandom()});
    split_conv(a, b);
    exp_q.push_back(model_prod(a, b));
    send_beat(cbuf[0], 3'd0);
    check_bit("t6_err_clear", bus.err, 1'b0);
    send_beat(COEF_W'(38'h123), 3'd2);
    check_bit("t6_err_set", bus.err, 1'b1);
    for (int i = 1; i < NCOEF; i++) send_beat(cbuf[i], IDX_W'(i));
    drain(20);
    check_bit("t6_err_sticky", bus.err, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_bit("t6_err_flushed", bus.err, 1'b0);
`else
    check_bit("t6_err_tied", bus.err, 1'b0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
